// File: rtl/tuser_in_arb.sv
// Packet-granular round-robin arbiter that merges NUM_PORTS AXIS ingress streams
// onto the single tuser_in_fsm input. The source port index is stamped into tuser.
module tuser_in_arb #(
  parameter int unsigned NUM_PORTS   = 4,
  parameter int unsigned PORT_ID_W   = 2,
  parameter int unsigned PORT_ID_LSB = 64
) (
  input  logic                       arb_aclk,
  input  logic                       arb_arst,
  input  logic [NUM_PORTS-1:0]       arb_svalid,
  output logic [NUM_PORTS-1:0]       arb_sready,
  input  logic [NUM_PORTS*256-1:0]   arb_sdata,
  input  logic [NUM_PORTS*32-1:0]    arb_skeep,
  input  logic [NUM_PORTS-1:0]       arb_stlast,
  input  logic [NUM_PORTS*128-1:0]   arb_stuser,
  output logic                       arb_mvalid,
  input  logic                       arb_mready,
  output logic [255:0]               arb_mdata,
  output logic [31:0]                arb_mkeep,
  output logic                       arb_mtlast,
  output logic [127:0]               arb_mtuser,
  output logic [PORT_ID_W-1:0]       arb_grant,
  output logic [1:0]                 dbg_state
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] PKT   = 2'd2;

  logic [1:0]           state;
  logic [PORT_ID_W-1:0] grant_q;
  logic [PORT_ID_W-1:0] last_grant;
  logic [PORT_ID_W-1:0] next_grant;
  logic                 found;
  int unsigned          idx;
  logic                 xfer_last;

  // Round-robin search: first requester strictly after last_grant, wrapping modulo NUM_PORTS.
  always_comb begin
    next_grant = '0;
    found      = 1'b0;
    idx        = 0;
    for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
      idx = (32'(last_grant) + i) % NUM_PORTS;
      if (!found && 1'(arb_svalid >> idx)) begin
        found      = 1'b1;
        next_grant = PORT_ID_W'(idx);
      end
    end
  end

  // Data path is a pure mux on the registered grant; only valid/ready are gated by state.
  always_comb begin
    arb_mdata  = 256'(arb_sdata  >> {grant_q, 8'h00});
    arb_mkeep  = 32'(arb_skeep   >> {grant_q, 5'h00});
    arb_mtlast = 1'(arb_stlast   >> grant_q);
    arb_mtuser = 128'(arb_stuser >> {grant_q, 7'h00});
    arb_mtuser[PORT_ID_LSB +: PORT_ID_W] = grant_q;
    arb_mvalid = 1'b0;
    arb_sready = '0;
    if (state == PKT) begin
      arb_mvalid = 1'(arb_svalid >> grant_q);
      arb_sready = NUM_PORTS'(arb_mready) << grant_q;
    end
  end

  assign xfer_last = (state == PKT) && arb_mvalid && arb_mready && arb_mtlast;

  always_ff @(posedge arb_aclk) begin
    if (arb_arst) begin
      state      <= IDLE;
      grant_q    <= '0;
      last_grant <= PORT_ID_W'(NUM_PORTS - 1);
    end else begin
      case (state)
        IDLE: begin
          if (|arb_svalid) begin
            grant_q <= next_grant;
            state   <= GRANT;
          end
        end
        GRANT: state <= PKT;
        PKT: begin
          if (xfer_last) begin
            last_grant <= grant_q;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign arb_grant = grant_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_tuser_in_arb.sv
// Directed bench for tuser_in_arb: per-port beat queues feed the DUT while a
// separate monitor pops expected beats from a scoreboard on every output transfer.
module tb_tuser_in_arb;

  localparam int NP = 4;

  typedef struct packed {
    logic [255:0] data;
    logic [31:0]  keep;
    logic         last;
    logic [127:0] tuser;
    logic         idle;
  } beat_t;

  typedef struct packed {
    logic [255:0] data;
    logic [31:0]  keep;
    logic         last;
    logic [127:0] tuser;
    logic [1:0]   grant;
  } exp_t;

  logic                  arb_aclk;
  logic                  arb_arst;
  logic [NP-1:0]         arb_svalid;
  logic [NP-1:0]         arb_sready;
  logic [NP-1:0][255:0]  arb_sdata;
  logic [NP-1:0][31:0]   arb_skeep;
  logic [NP-1:0]         arb_stlast;
  logic [NP-1:0][127:0]  arb_stuser;
  logic                  arb_mvalid;
  logic                  arb_mready;
  logic [255:0]          arb_mdata;
  logic [31:0]           arb_mkeep;
  logic                  arb_mtlast;
  logic [127:0]          arb_mtuser;
  logic [1:0]            arb_grant;
  logic [1:0]            dbg_state;

  tuser_in_arb #(
    .NUM_PORTS   (NP),
    .PORT_ID_W   (2),
    .PORT_ID_LSB (64)
  ) dut (
    .arb_aclk   (arb_aclk),
    .arb_arst   (arb_arst),
    .arb_svalid (arb_svalid),
    .arb_sready (arb_sready),
    .arb_sdata  (arb_sdata),
    .arb_skeep  (arb_skeep),
    .arb_stlast (arb_stlast),
    .arb_stuser (arb_stuser),
    .arb_mvalid (arb_mvalid),
    .arb_mready (arb_mready),
    .arb_mdata  (arb_mdata),
    .arb_mkeep  (arb_mkeep),
    .arb_mtlast (arb_mtlast),
    .arb_mtuser (arb_mtuser),
    .arb_grant  (arb_grant),
    .dbg_state  (dbg_state)
  );

  initial begin
    arb_aclk = 1'b0;
    forever #5 arb_aclk = ~arb_aclk;
  end

  beat_t         pq [NP][$];
  exp_t          exp_q[$];
  logic [NP-1:0] acc;
  logic [NP-1:0] cur_idle;
  int            pulses [NP];
  int            n_checks;
  int            n_fail;
  logic          toggle_mode;
  logic          mirror_mode;
  logic [1:0]    mirror_port;
  int            cyc;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic push_pkt(input logic [1:0] p, input int nb, input logic [255:0] d0,
                          input logic [31:0] k, input logic [127:0] u,
                          input int gap_at, input int gap_len, input int exp_n);
    beat_t b;
    exp_t  e;
    for (int i = 0; i < nb; i++) begin
      if (i == gap_at) begin
        for (int j = 0; j < gap_len; j++) begin
          b      = '0;
          b.idle = 1'b1;
          pq[p].push_back(b);
        end
      end
      b.idle  = 1'b0;
      b.data  = d0 + 256'(i);
      b.keep  = k;
      b.last  = (i == nb - 1);
      b.tuser = u;
      pq[p].push_back(b);
      if (i < exp_n) begin
        e.data  = b.data;
        e.keep  = k;
        e.last  = b.last;
        e.tuser = u;
        e.tuser[65:64] = p;
        e.grant = p;
        exp_q.push_back(e);
      end
    end
  endtask

  // One clock: retire accepted beats, drive the next ones after the edge, sample at negedge.
  task automatic step(input logic rst = 1'b0);
    logic [1:0] pi;
    beat_t      b;
    @(posedge arb_aclk);
    #1;
    arb_arst = rst;
    for (int p = 0; p < NP; p++) begin
      pi = 2'(p);
      if ((acc[pi] || cur_idle[pi]) && pq[pi].size() > 0) void'(pq[pi].pop_front());
      cur_idle[pi]   = 1'b0;
      arb_svalid[pi] = 1'b0;
      if (pq[pi].size() > 0) begin
        b = pq[pi][0];
        if (b.idle) cur_idle[pi] = 1'b1;
        else begin
          arb_svalid[pi] = 1'b1;
          arb_sdata[pi]  = b.data;
          arb_skeep[pi]  = b.keep;
          arb_stlast[pi] = b.last;
          arb_stuser[pi] = b.tuser;
        end
      end
    end
    if (toggle_mode) arb_mready = (cyc % 4 == 0) || (cyc % 4 == 3);
    else             arb_mready = 1'b1;
    cyc++;
    @(negedge arb_aclk);
    for (int p = 0; p < NP; p++) begin
      pi = 2'(p);
      acc[pi] = arb_svalid[pi] && arb_sready[pi];
      if (arb_sready[pi]) pulses[pi]++;
    end
    if (mirror_mode && dbg_state == 2'd2)
      chk("t4_sready_mirror", 256'(arb_sready), 256'(4'(arb_mready) << mirror_port));
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!(pq[0].size() == 0 && pq[1].size() == 0 && pq[2].size() == 0 &&
                 pq[3].size() == 0 && dbg_state == 2'd0) && n < 300);
    n_checks++;
    if (n >= 300) begin
      n_fail++;
      $display("FAIL %s_timeout: actual %0d cycles required under 300", name, n);
    end
  endtask

  task automatic do_reset();
    repeat (3) step(1'b1);
    step(1'b0);
    for (int p = 0; p < NP; p++) pulses[p] = 0;
  endtask

  // Scoreboard monitor: every accepted output beat must match the next expected beat.
  initial begin
    exp_t e;
    forever begin
      @(negedge arb_aclk);
      if (!arb_arst && arb_mvalid && arb_mready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL mon_unexpected_beat: actual data %0h required no beat", arb_mdata);
        end else begin
          e = exp_q.pop_front();
          chk("mon_data",  arb_mdata,  e.data);
          chk("mon_keep",  256'(arb_mkeep),  256'(e.keep));
          chk("mon_tlast", 256'(arb_mtlast), 256'(e.last));
          chk("mon_tuser", 256'(arb_mtuser), 256'(e.tuser));
          chk("mon_grant", 256'(arb_grant),  256'(e.grant));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual simulation still running required finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int gapc;
    n_checks    = 0;
    n_fail      = 0;
    arb_arst    = 1'b1;
    arb_svalid  = '0;
    arb_sdata   = '0;
    arb_skeep   = '0;
    arb_stlast  = '0;
    arb_stuser  = '0;
    arb_mready  = 1'b1;
    toggle_mode = 1'b0;
    mirror_mode = 1'b0;
    mirror_port = 2'd0;
    cyc         = 0;
    acc         = '0;
    cur_idle    = '0;

    do_reset();
    chk("rst_state",  256'(dbg_state),  256'd0);
    chk("rst_grant",  256'(arb_grant),  256'd0);
    chk("rst_mvalid", 256'(arb_mvalid), 256'd0);
    chk("rst_sready", 256'(arb_sready), 256'd0);

    // Single request on port 2, 3 beats
    push_pkt(2'd2, 3, 256'h22222, 32'h33333, 128'h44444, -1, 0, 3);
    step();
    chk("t1_idle_state",    256'(dbg_state),  256'd0);
    chk("t1_idle_mvalid",   256'(arb_mvalid), 256'd0);
    step();
    chk("t1_grant_state",   256'(dbg_state),  256'd1);
    chk("t1_grant",         256'(arb_grant),  256'd2);
    chk("t1_grant_mvalid",  256'(arb_mvalid), 256'd0);
    step();
    chk("t1_pkt_state",     256'(dbg_state),  256'd2);
    chk("t1_mvalid_cyc2",   256'(arb_mvalid), 256'd1);
    chk("t1_port_id",       256'(arb_mtuser[65:64]), 256'd2);
    chk("t1_sready",        256'(arb_sready), 256'b0100);
    wait_idle("t1");

    // All ports request single-beat packets; stamped id must overwrite tuser[65:64]=01
    do_reset();
    for (int p = 0; p < NP; p++)
      push_pkt(2'(p), 1, 256'hA0 + 256'(p), 32'hFFFF_FFFF, {62'h0, 2'b01, 64'hC0DE_0000}, -1, 0, 1);
    wait_idle("t2");
    for (int p = 0; p < NP; p++) chk("t2_sready_pulses", 256'(pulses[p]), 256'd1);

    // Port 1 requests while port 0 is mid-packet
    push_pkt(2'd0, 4, 256'h3000, 32'h0F0F, 128'h3333, -1, 0, 4);
    repeat (3) step();
    push_pkt(2'd1, 2, 256'h3100, 32'hF0F0, 128'h3111, -1, 0, 2);
    n = 0;
    while (pq[0].size() > 0 && n < 50) begin
      step();
      chk("t3_p1_blocked", 256'(arb_sready[1]), 256'd0);
      n++;
    end
    wait_idle("t3");
    chk("t3_grant", 256'(arb_grant), 256'd1);

    // Backpressure pattern 1,0,0,1 on a 4-beat packet from port 2
    cyc         = 0;
    toggle_mode = 1'b1;
    mirror_mode = 1'b1;
    mirror_port = 2'd2;
    push_pkt(2'd2, 4, 256'h4000, 32'h1234, 128'h4444, -1, 0, 4);
    wait_idle("t4");
    toggle_mode = 1'b0;
    mirror_mode = 1'b0;

    // Reset during beat 2 of a port-3 packet; only beat 1 is ever transferred
    push_pkt(2'd3, 4, 256'h5000, 32'h5555, 128'h5050, -1, 0, 1);
    repeat (3) step();
    step(1'b1);
    pq[3].delete();
    step(1'b0);
    chk("t5_mvalid", 256'(arb_mvalid), 256'd0);
    chk("t5_sready", 256'(arb_sready), 256'd0);
    chk("t5_state",  256'(dbg_state),  256'd0);
    chk("t5_grant",  256'(arb_grant),  256'd0);
    push_pkt(2'd0, 1, 256'h5200, 32'h0001, 128'h5200, -1, 0, 1);
    push_pkt(2'd3, 1, 256'h5100, 32'h0003, 128'h5100, -1, 0, 1);
    wait_idle("t5");
    chk("t5_last_grant", 256'(arb_grant), 256'd3);

    // Port 1 drops valid for 3 cycles mid-packet while port 2 waits
    push_pkt(2'd1, 4, 256'h6000, 32'h6666, 128'h6060, 2, 3, 4);
    repeat (3) step();
    push_pkt(2'd2, 2, 256'h6100, 32'h6161, 128'h6161, -1, 0, 2);
    n    = 0;
    gapc = 0;
    while (pq[1].size() > 0 && n < 50) begin
      step();
      chk("t6_p2_blocked", 256'(arb_sready[2]), 256'd0);
      if (dbg_state == 2'd2 && !arb_mvalid) gapc++;
      n++;
    end
    chk("t6_gap_cycles_in_pkt", 256'(gapc), 256'd3);
    wait_idle("t6");
    chk("t6_grant", 256'(arb_grant), 256'd2);

    repeat (3) step();
    chk("all_expected_beats_seen", 256'(exp_q.size()), 256'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tuser_in_arb.md
Name: tuser_in_arb

Overview:
- Packet-granular round-robin arbiter sharing one tuser_in_fsm input between NUM_PORTS AXIS ingress streams.
- Sits directly upstream of tuser_in_fsm and drives its tin_a* interface.
- Once a port is granted, the grant is held until that packet's tlast beat is accepted. Beats of different packets are never interleaved.
- Stamps the source port index into a fixed tuser field so downstream stages can identify the origin.

Parameters:
- NUM_PORTS, 4, number of ingress streams (2..8).
- PORT_ID_W, 2, width of stamped port-ID field; must satisfy 2^PORT_ID_W >= NUM_PORTS.
- PORT_ID_LSB, 64, LSB position of the port-ID field inside the 128-bit tuser.

Ports:
- arb_aclk  in  1  clock
- arb_arst  in  1  synchronous active-high reset
- arb_svalid  in  NUM_PORTS  per-port valid
- arb_sready  out  NUM_PORTS  per-port ready
- arb_sdata  in  NUM_PORTS*256  per-port data; port p at [p*256 +: 256]
- arb_skeep  in  NUM_PORTS*32  per-port keep
- arb_stlast  in  NUM_PORTS  per-port tlast
- arb_stuser  in  NUM_PORTS*128  per-port tuser
- arb_mvalid  out  1  to tin_avalid
- arb_mready  in  1  from tin_aready
- arb_mdata  out  256  to tin_adata
- arb_mkeep  out  32  to tin_akeep
- arb_mtlast  out  1  to tin_atlast
- arb_mtuser  out  128  to tin_atuser
- arb_grant  out  PORT_ID_W  currently/last granted port
- dbg_state  out  2  FSM state encoding

Behaviour:
- One clock domain. Reset is synchronous and active-high on arb_arst, sampled on the rising edge of arb_aclk.
- Reset values:
  - state = IDLE; arb_grant = 0.
  - last_grant = NUM_PORTS-1, so port 0 has first priority.
  - arb_mvalid = 0; arb_sready = all 0; dbg_state = 0.
- States (dbg_state encoding): IDLE=0, GRANT=1, PKT=2.
- IDLE:
  - All arb_sready = 0; arb_mvalid = 0.
  - If any arb_svalid bit is 1, register grant = first requesting port searching from last_grant+1 upward with wrap (modulo NUM_PORTS), then go to GRANT.
- GRANT:
  - Single bubble cycle; outputs are still idle.
  - Always go to PKT. Arbitration latency: first beat can be accepted 2 cycles after svalid rises in IDLE.
- PKT (combinational mux on the registered grant g):
  - arb_mvalid = arb_svalid[g]; arb_sready[g] = arb_mready; all other arb_sready = 0.
  - arb_mdata, arb_mkeep, arb_mtlast, arb_mtuser are port g's fields.
  - arb_mtuser[PORT_ID_LSB +: PORT_ID_W] is overwritten with g; all other tuser bits pass through unchanged.
  - A beat transfers when arb_mvalid && arb_mready.
  - On a transfer with tlast=1: last_grant = g, next state = IDLE.
- Idle cycles mid-packet:
  - If the granted port drops svalid, stay in PKT with no timeout.
  - Other ports stay blocked until tlast.
- Single-beat packets (tlast on the first beat) are legal: one transfer, then back to IDLE.
- Back-to-back:
  - The cycle after tlast is IDLE. A new request is arbitrated there.
  - Minimum 2 dead cycles between packets.
- Simultaneous requests resolve purely by round-robin order. Request changes during GRANT/PKT do not alter the grant.
- arb_grant holds its value outside PKT; it updates only at the IDLE->GRANT transition.
- Reset mid-packet: at the reset edge the state returns to IDLE. From the next cycle arb_mvalid = 0 and arb_sready = 0. The partial packet is truncated; no recovery tlast is generated.
- Data is never registered. The block adds zero data latency once in PKT and must not drop or duplicate beats under arbitrary mready backpressure.

Test Plan:
- Single request: port 2 sends a 3-beat packet (data 22222, keep 33333, tuser 44444, tlast on beat 3), mready=1.
  -> grant=2; mvalid at cycle +2; 3 beats out; mtuser[65:64]=2; IDLE after beat 3.
- All four ports request 1-beat packets simultaneously after reset.
  -> grant order 0,1,2,3; each port sees exactly one sready pulse.
- Port 0 mid-packet (beat 2 of 4) while port 1 requests.
  -> port 1 sready stays 0 until port 0 tlast transfers; then grant=1.
- mready toggles 1,0,0,1,... during a 4-beat packet.
  -> exactly 4 transfers, in order, no duplicates; sready[g] mirrors mready.
- arb_arst asserted during beat 2 of a packet on port 3.
  -> next cycle mvalid=0, sready=0, dbg_state=0, grant=0; next request arbitrates from port 0.
- Port 1 drops svalid for 3 cycles mid-packet while port 2 requests.
  -> state stays PKT (dbg_state=2), mvalid=0 during the gap, port 2 blocked until port 1 tlast.
